// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches and holds returned
// instructions in a small in-order prefetch FIFO, flushing on redirect.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam int              CNT_W      = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PTR_W-1:0] head_ptr, tail_ptr, fill_ptr;
  logic [CNT_W-1:0] alloc_count, unfilled_count, inflight, drop_cnt;
  logic [CNT_W-1:0] inflight_dec;

  logic head_ready, req_fire, pop, rsp_ret, rsp_drop, rsp_fill;

  always_comb begin
    head_ready     = (alloc_count != '0) && filled[head_ptr];
    imem_req_valid = !reset && !redirect_valid &&
                     (alloc_count < CNT_FULL) && (inflight < CNT_FULL);
    req_fire       = imem_req_valid && imem_req_ready;
    inst_valid     = head_ready && !redirect_valid;
    pop            = inst_valid && inst_ready;
    rsp_ret        = imem_rsp_valid && (inflight != '0);
    rsp_drop       = imem_rsp_valid && !redirect_valid && (drop_cnt != '0);
    rsp_fill       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) &&
                     (unfilled_count != '0);
    inflight_dec   = inflight - (rsp_ret ? CNT_ONE : '0);
  end

  assign imem_req_addr = fetch_pc;
  assign inst_data     = head_ready ? data_mem[head_ptr] : '0;
  assign inst_pc       = head_ready ? pc_mem[head_ptr] : '0;
  assign inst_pc_plus4 = head_ready ? pc_mem[head_ptr] + PC_STEP : '0;

  // After a redirect every outstanding response belongs to the old stream,
  // so the drop count is simply what remains in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      head_ptr       <= '0;
      tail_ptr       <= '0;
      fill_ptr       <= '0;
      alloc_count    <= '0;
      unfilled_count <= '0;
      inflight       <= '0;
      drop_cnt       <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= redirect_target & ALIGN_MASK;
      head_ptr       <= '0;
      tail_ptr       <= '0;
      fill_ptr       <= '0;
      alloc_count    <= '0;
      unfilled_count <= '0;
      inflight       <= inflight_dec;
      drop_cnt       <= inflight_dec;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
        tail_ptr <= tail_ptr + PTR_ONE;
      end
      if (pop)      head_ptr <= head_ptr + PTR_ONE;
      if (rsp_fill) fill_ptr <= fill_ptr + PTR_ONE;
      if (rsp_drop) drop_cnt <= drop_cnt - CNT_ONE;
      alloc_count    <= alloc_count + (req_fire ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      unfilled_count <= unfilled_count + (req_fire ? CNT_ONE : '0) -
                        (rsp_fill ? CNT_ONE : '0);
      inflight       <= inflight_dec + (req_fire ? CNT_ONE : '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      filled <= '0;
    end else begin
      if (req_fire) begin
        pc_mem[tail_ptr] <= fetch_pc;
        filled[tail_ptr] <= 1'b0;
      end
      if (rsp_fill) begin
        data_mem[fill_ptr] <= imem_rsp_data;
        filled[fill_ptr]   <= 1'b1;
      end
    end
  end

endmodule
